counter_bank: RTL and testbench
===============================

# counter_bank

Multi-channel, runtime-programmable modulo counter bank for tick and strobe generation, such as baud, symbol and sample-rate strobes in the transmit chain. It supersedes the fixed-modulus single counter. Each of CHANNELS independent channels holds its own modulus, free-run/one-shot mode and count, and emits a one-cycle registered terminal-count pulse. A valid/ready configuration port rewrites any channel at run time without disturbing the others.

## Interface
- CHANNELS, 4: number of independent counter channels, 1..16.
- WIDTH, 26: count and modulus width in bits; covers 50 000 000.
- DEFAULT_MODULE, 50000000: modulus loaded into every channel at reset; must fit in WIDTH.
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  CHANNELS  per-channel count enable, sampled each clk.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  bank can accept a request.
- cfg_chan  in  max(1,$clog2(CHANNELS))  target channel.
- cfg_module  in  WIDTH  new modulus.
- cfg_oneshot  in  1  1 = one-shot mode, 0 = free-run.
- tc  out  CHANNELS  registered terminal-count pulse per channel.
- busy  out  CHANNELS  channel armed and not finished.
- count  out  CHANNELS*WIDTH  current counts; channel i is at bits [i*WIDTH +: WIDTH].

## Operation
- Each channel holds `mod_r`, `oneshot_r`, `done_r` and `cnt`.
- **Counting:** on a clk edge with enable[i]=1 and done_r=0, cnt increments.
  - If cnt == mod_r-1 at that edge, cnt goes to 0 and tc[i] is 1 for the next cycle.
  - In one-shot mode, done_r also sets at that edge.
- **tc default:** tc[i] is 0 in every other cycle.
- **Enable low:** cnt holds its value and no tc is produced.
- **One-shot finished:** with done_r=1 the channel ignores enable and cnt stays 0 until the channel is reconfigured.
- **busy[i]** = ~done_r, registered. It is 1 in free-run mode.
- **Configuration accept:** a request is accepted when cfg_valid & cfg_ready.
  - The target channel loads mod_r=cfg_module and oneshot_r=cfg_oneshot.
  - It also clears cnt and done_r. All of this happens at the accepting edge.
  - No tc is generated by that edge for that channel.
- **cfg_module clamp:** cfg_module = 0 is clamped to 1.
  - Modulus 1 gives cnt constantly 0 and tc high on every enabled cycle: the cycle after each enabled edge.
- **Invalid channel:** cfg_chan >= CHANNELS is accepted and has no effect.
- **Write vs terminal on the same channel:** the configuration write wins and tc is suppressed.
- **Write to another channel:** independent; that channel's terminal proceeds normally.
- **cfg_ready:** 0 in reset, 1 from the first edge after rst deasserts, then constantly 1. There is no back-pressure. The port is a handshake so a future shared-bus front end can stall it.

## Timing
- **Reset values:** cnt=0, mod_r=DEFAULT_MODULE, oneshot_r=0, done_r=0, tc=0, busy=all ones, cfg_ready=0.
- **Reset mid-count:** returns the bank to reset values asynchronously, including any tc pulse in flight.
- **tc latency:** tc rises one cycle after the edge at which cnt == mod_r-1 with enable high.
- **Period:** with enable held high, the tc period is exactly mod_r cycles.
- **New modulus:** takes effect for the count starting at the accept edge. The first tc after a write comes mod_r enabled edges later.
- **count output:** a direct register output with zero latency.
- **Combinational paths:** none from inputs to outputs.

## Configuration
- `COUNTER_BANK_CASCADE_EN` adds input `cfg_cascade` (1 bit) and a per-channel `cascade_r`, which resets to 0 and is loaded on configuration.
  - With cascade_r=1, channel i>0 advances only on edges where enable[i] & tc[i-1] is 1.
  - This lets chains form long prescalers.
  - cascade_r is ignored on channel 0.
- Without the macro there is no cfg_cascade port, and every channel uses only its own enable.

## Structure
- Package `counter_bank_pkg`: channel-index width function, modulus clamp function, and a packed channel-config typedef (module, oneshot, cascade under the macro).
- Sub-module `counter_chan`: one channel, meaning counter, modulus register, one-shot flag and tc register, with a load strobe.
- Top level: decodes cfg_chan into per-channel load strobes, instantiates CHANNELS copies, concatenates count and routes the cascade chain.

## Test plan
- **Reset defaults:** reset, then CHANNELS=4 with DEFAULT_MODULE=5 and all enables high.
  - Required: each tc pulses at cycles 5, 10, 15 after reset release.
  - Required: cfg_ready=1 one edge after release.
- **Free-run reprogram:** write ch2 modulus 3 with oneshot 0 mid-count.
  - Required: ch2 count restarts at 0 and tc[2] pulses every 3 cycles.
  - Required: the other channels are undisturbed.
- **One-shot:** write ch1 modulus 4 with oneshot 1.
  - Required: exactly one tc[1], 4 cycles after accept; busy[1] falls with it; count[1] stays 0 afterwards.
  - Rewrite ch1 to re-arm. Required: busy[1] returns to 1 and tc[1] pulses once more.
- **Enable gap and reset:** toggle enable[0] low for 3 cycles at cnt=2 with modulus 5.
  - Required: the tc period stretches to 8 cycles.
  - Assert rst mid-count. Required: all outputs return to reset values immediately.
- **Collisions and clamps:**
  - Write ch3 on the same edge its cnt == mod-1. Required: no tc[3].
  - Write cfg_module=0. Required: tc[3] high every enabled cycle.
  - Write cfg_chan=5. Required: no channel changes.
- **Cascade (with `COUNTER_BANK_CASCADE_EN`):** ch0 modulus 4, ch1 modulus 3 with cascade=1.
  - Required: tc[1] period of 12 cycles.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: shared types and helpers for the counter bank.
// Provides the channel-index width, modulus clamp and packed channel config.
// Optional feature macro: COUNTER_BANK_CASCADE_EN (adds the cascade bit).
package counter_bank_pkg;

    localparam int MAX_WIDTH = 32;

    typedef logic [MAX_WIDTH-1:0] mod_t;

    typedef struct packed {
        mod_t modulus;
        logic oneshot;
`ifdef COUNTER_BANK_CASCADE_EN
        logic cascade;
`endif
    } chan_cfg_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int chan_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // A zero modulus has no meaning; treat it as divide-by-one.
    function automatic mod_t clamp_mod(input mod_t m);
        return (m == '0) ? mod_t'(1) : m;
    endfunction

endpackage

// File: rtl/counter_bank_if.sv
// counter_bank_if: valid/ready configuration port of the counter bank.
// Signals: cfg_valid, cfg_ready, cfg_chan, cfg_module, cfg_oneshot
// (+ cfg_cascade when COUNTER_BANK_CASCADE_EN is defined).
// master drives the request, slave (the bank) returns cfg_ready.
interface counter_bank_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 26
);
    import counter_bank_pkg::*;

    localparam int CW = chan_w(CHANNELS);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CW-1:0]    cfg_chan;
    logic [WIDTH-1:0] cfg_module;
    logic             cfg_oneshot;
`ifdef COUNTER_BANK_CASCADE_EN
    logic             cfg_cascade;
`endif

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_module,
        output cfg_oneshot,
`ifdef COUNTER_BANK_CASCADE_EN
        output cfg_cascade,
`endif
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_module,
        input  cfg_oneshot,
`ifdef COUNTER_BANK_CASCADE_EN
        input  cfg_cascade,
`endif
        output cfg_ready
    );

endinterface

// File: rtl/counter_bank_chan.sv
// counter_chan: one modulo counter channel with modulus register,
// one-shot flag and registered terminal-count pulse.
// Ports: clk, rst (async, active high), load_i + cfg_i (reconfigure),
// enable_i, prev_tc_i (cascade only), tc_o, busy_o, cnt_o.
// Optional feature macro: COUNTER_BANK_CASCADE_EN.
module counter_chan
    import counter_bank_pkg::*;
#(
    parameter int WIDTH          = 26,
`ifdef COUNTER_BANK_CASCADE_EN
    parameter bit FIRST          = 1'b1,
`endif
    parameter int DEFAULT_MODULE = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  chan_cfg_t        cfg_i,
    input  logic             enable_i,
`ifdef COUNTER_BANK_CASCADE_EN
    input  logic             prev_tc_i,
`endif
    output logic             tc_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic             oneshot_q, oneshot_d;
    logic             done_q, done_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             step;

`ifdef COUNTER_BANK_CASCADE_EN
    logic cascade_q, cascade_d;

    // The head of a chain has no upstream tc, so its cascade bit is moot.
    assign step = enable_i & (FIRST | ~cascade_q | prev_tc_i);
`else
    assign step = enable_i;
`endif

    always_comb begin
        cnt_d     = cnt_q;
        mod_d     = mod_q;
        oneshot_d = oneshot_q;
        done_d    = done_q;
        tc_d      = 1'b0;
`ifdef COUNTER_BANK_CASCADE_EN
        cascade_d = cascade_q;
`endif
        // A write outranks a terminal count on the same edge.
        if (load_i) begin
            mod_d     = WIDTH'(clamp_mod(cfg_i.modulus));
            oneshot_d = cfg_i.oneshot;
            cnt_d     = '0;
            done_d    = 1'b0;
`ifdef COUNTER_BANK_CASCADE_EN
            cascade_d = cfg_i.cascade;
`endif
        end else if (step && !done_q) begin
            if (cnt_q == mod_q - WIDTH'(1)) begin
                cnt_d = '0;
                tc_d  = 1'b1;
                if (oneshot_q) begin
                    done_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
        busy_d = ~done_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            mod_q     <= WIDTH'(DEFAULT_MODULE);
            oneshot_q <= 1'b0;
            done_q    <= 1'b0;
            tc_q      <= 1'b0;
            busy_q    <= 1'b1;
`ifdef COUNTER_BANK_CASCADE_EN
            cascade_q <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            mod_q     <= mod_d;
            oneshot_q <= oneshot_d;
            done_q    <= done_d;
            tc_q      <= tc_d;
            busy_q    <= busy_d;
`ifdef COUNTER_BANK_CASCADE_EN
            cascade_q <= cascade_d;
`endif
        end
    end

    assign tc_o   = tc_q;
    assign busy_o = busy_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/counter_bank.sv
// counter_bank: CHANNELS independent programmable modulo counters with a
// valid/ready configuration port (counter_bank_if.slave).
// Ports: clk, rst (async, active high), cfg, enable, tc, busy, count.
// Optional feature macro: COUNTER_BANK_CASCADE_EN (channel chaining).
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int WIDTH          = 26,
    parameter int DEFAULT_MODULE = 50000000
) (
    input  logic                      clk,
    input  logic                      rst,
    counter_bank_if.slave             cfg,
    input  logic [CHANNELS-1:0]       enable,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS*WIDTH-1:0] count
);

    localparam int CW = chan_w(CHANNELS);

    logic      ready_q, ready_d;
    logic      accept;
    chan_cfg_t cfg_w;

    // No back-pressure today; ready only waits out reset.
    always_comb ready_d = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign accept        = cfg.cfg_valid & ready_q;

    always_comb begin
        cfg_w         = '0;
        cfg_w.modulus = mod_t'(cfg.cfg_module);
        cfg_w.oneshot = cfg.cfg_oneshot;
`ifdef COUNTER_BANK_CASCADE_EN
        cfg_w.cascade = cfg.cfg_cascade;
`endif
    end

    // Out-of-range channel indices match no strobe and are dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic load;

        assign load = accept && (cfg.cfg_chan == CW'(i));

`ifdef COUNTER_BANK_CASCADE_EN
        logic prev_tc;

        if (i == 0) begin : g_head
            assign prev_tc = 1'b0;
        end else begin : g_link
            assign prev_tc = tc[i-1];
        end

        counter_chan #(
            .WIDTH          (WIDTH),
            .FIRST          (i == 0),
            .DEFAULT_MODULE (DEFAULT_MODULE)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .load_i    (load),
            .cfg_i     (cfg_w),
            .enable_i  (enable[i]),
            .prev_tc_i (prev_tc),
            .tc_o      (tc[i]),
            .busy_o    (busy[i]),
            .cnt_o     (count[i*WIDTH +: WIDTH])
        );
`else
        counter_chan #(
            .WIDTH          (WIDTH),
            .DEFAULT_MODULE (DEFAULT_MODULE)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .load_i   (load),
            .cfg_i    (cfg_w),
            .enable_i (enable[i]),
            .tc_o     (tc[i]),
            .busy_o   (busy[i]),
            .cnt_o    (count[i*WIDTH +: WIDTH])
        );
`endif
    end

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: directed, table-driven bench for counter_bank.
// A second 3-channel bank exercises an out-of-range cfg_chan.
module tb_counter_bank;

    localparam int CH = 4;
    localparam int W  = 26;
    localparam int DM = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   enable, tc, busy;
    logic [CH*W-1:0] count;
    logic [2:0]      enable3, tc3, busy3;
    logic [23:0]     count3;

    counter_bank_if #(.CHANNELS(CH), .WIDTH(W)) cfg_if ();
    counter_bank_if #(.CHANNELS(3), .WIDTH(8)) cfg3_if ();

    counter_bank #(
        .CHANNELS(CH), .WIDTH(W), .DEFAULT_MODULE(DM)
    ) u_dut (
        .clk(clk), .rst(rst), .cfg(cfg_if), .enable(enable),
        .tc(tc), .busy(busy), .count(count)
    );

    // With 4 channels cfg_chan is 2 bits and cannot hold an invalid
    // index, so a 3-channel bank is used where index 3 is out of range.
    counter_bank #(
        .CHANNELS(3), .WIDTH(8), .DEFAULT_MODULE(DM)
    ) u_dut3 (
        .clk(clk), .rst(rst), .cfg(cfg3_if), .enable(enable3),
        .tc(tc3), .busy(busy3), .count(count3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] en;
        logic [3:0] tc;
        int         c0;
        int         c1;
    } vec_t;

    vec_t tbl [15];

    function automatic logic [W-1:0] cnt(input int i);
        return count[i*W +: W];
    endfunction

    function automatic logic [7:0] cnt3(input int i);
        return count3[i*8 +: 8];
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " tc"},     64'(tc),     64'(0));
        chk({tag, " busy"},   64'(busy),   64'(4'hF));
        chk({tag, " ready"},  64'(cfg_if.cfg_ready), 64'(0));
        chk({tag, " cnt0"},   64'(cnt(0)), 64'(0));
        chk({tag, " cnt3"},   64'(cnt(3)), 64'(0));
        chk({tag, " tc3"},    64'(tc3),    64'(0));
    endtask

    // Leaves rst released at a negedge so the next posedge is edge 1.
    task automatic do_reset();
        rst = 1'b1;
        enable = '0;
        enable3 = '0;
        cfg_if.cfg_valid = 1'b0;
        cfg3_if.cfg_valid = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input int m, input logic os,
                             input logic cas);
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_chan    = 2'(ch);
        cfg_if.cfg_module  = W'(m);
        cfg_if.cfg_oneshot = os;
`ifdef COUNTER_BANK_CASCADE_EN
        cfg_if.cfg_cascade = cas;
`else
        if (cas) $display("note: cascade ignored in this build");
`endif
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_chan = '0;
        cfg_if.cfg_module = '0;
        cfg_if.cfg_oneshot = 1'b0;
        cfg3_if.cfg_valid = 1'b0;
        cfg3_if.cfg_chan = '0;
        cfg3_if.cfg_module = '0;
        cfg3_if.cfg_oneshot = 1'b0;
`ifdef COUNTER_BANK_CASCADE_EN
        cfg_if.cfg_cascade = 1'b0;
        cfg3_if.cfg_cascade = 1'b0;
`endif
        rst = 1'b0;
        enable = '0;
        enable3 = '0;

        // Edge-by-edge after reset release, modulus 5, enable[0]
        // dropped on edges 8..10 while cnt0 == 2.
        tbl[0]  = '{4'hF, 4'h0, 1, 1};
        tbl[1]  = '{4'hF, 4'h0, 2, 2};
        tbl[2]  = '{4'hF, 4'h0, 3, 3};
        tbl[3]  = '{4'hF, 4'h0, 4, 4};
        tbl[4]  = '{4'hF, 4'hF, 0, 0};
        tbl[5]  = '{4'hF, 4'h0, 1, 1};
        tbl[6]  = '{4'hF, 4'h0, 2, 2};
        tbl[7]  = '{4'hE, 4'h0, 2, 3};
        tbl[8]  = '{4'hE, 4'h0, 2, 4};
        tbl[9]  = '{4'hE, 4'hE, 2, 0};
        tbl[10] = '{4'hF, 4'h0, 3, 1};
        tbl[11] = '{4'hF, 4'h0, 4, 2};
        tbl[12] = '{4'hF, 4'h1, 0, 3};
        tbl[13] = '{4'hF, 4'h0, 1, 4};
        tbl[14] = '{4'hF, 4'hE, 2, 0};

        #2;
        rst = 1'b1;
        #3;
        chk_reset("reset");
        do_reset();
        chk("ready before edge1", 64'(cfg_if.cfg_ready), 64'(0));

        for (int k = 0; k < 15; k++) begin
            enable = tbl[k].en;
            tick();
            chk($sformatf("tbl%0d tc", k), 64'(tc), 64'(tbl[k].tc));
            chk($sformatf("tbl%0d cnt0", k), 64'(cnt(0)), 64'(tbl[k].c0));
            chk($sformatf("tbl%0d cnt1", k), 64'(cnt(1)), 64'(tbl[k].c1));
            chk($sformatf("tbl%0d cnt3", k), 64'(cnt(3)), 64'(tbl[k].c1));
            chk($sformatf("tbl%0d ready", k), 64'(cfg_if.cfg_ready), 64'(1));
            chk($sformatf("tbl%0d busy", k), 64'(busy), 64'(4'hF));
        end

        // tc[3:1] is high right now; reset must kill it at once.
        rst = 1'b1;
        #1;
        chk_reset("mid-count reset");
        do_reset();

        // Free-run reprogram of ch2 at edge 3.
        enable = 4'hF;
        tick();
        tick();
        cfg_write(2, 3, 1'b0, 1'b0);
        chk("reprog cnt2", 64'(cnt(2)), 64'(0));
        chk("reprog cnt0", 64'(cnt(0)), 64'(3));
        chk("reprog tc", 64'(tc), 64'(0));
        for (int e = 4; e <= 12; e++) begin
            logic o, t2;
            tick();
            o  = (e % 5) == 0;
            t2 = ((e - 3) % 3) == 0;
            chk($sformatf("reprog e%0d tc", e), 64'(tc),
                64'({o, t2, o, o}));
            chk($sformatf("reprog e%0d cnt2", e), 64'(cnt(2)),
                64'((e - 3) % 3));
            chk($sformatf("reprog e%0d cnt0", e), 64'(cnt(0)),
                64'(e % 5));
        end

        // One-shot on ch1, then re-arm.
        rst = 1'b1;
        do_reset();
        enable = 4'hF;
        tick();
        cfg_write(1, 4, 1'b1, 1'b0);
        chk("oneshot busy1 armed", 64'(busy[1]), 64'(1));
        chk("oneshot cnt1 cleared", 64'(cnt(1)), 64'(0));
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 10; k++) begin
                tick();
                chk($sformatf("os%0d k%0d tc1", r, k), 64'(tc[1]),
                    64'(k == 4));
                chk($sformatf("os%0d k%0d busy1", r, k), 64'(busy[1]),
                    64'(k < 4));
                chk($sformatf("os%0d k%0d cnt1", r, k), 64'(cnt(1)),
                    64'((k < 4) ? k : 0));
            end
            chk($sformatf("os%0d busy0", r), 64'(busy[0]), 64'(1));
            cfg_write(1, 4, 1'b1, 1'b0);
            chk($sformatf("os%0d rearm busy1", r), 64'(busy[1]), 64'(1));
        end

        // Collisions, clamp and invalid channel.
        rst = 1'b1;
        do_reset();
        enable = 4'hF;
        enable3 = 3'h7;
        tick();
        tick();
        cfg3_if.cfg_valid  = 1'b1;
        cfg3_if.cfg_chan   = 2'd3;
        cfg3_if.cfg_module = 8'd1;
        tick();
        cfg3_if.cfg_valid = 1'b0;
        chk("badchan cnt0", 64'(cnt3(0)), 64'(3));
        chk("badchan cnt1", 64'(cnt3(1)), 64'(3));
        chk("badchan cnt2", 64'(cnt3(2)), 64'(3));
        chk("badchan tc", 64'(tc3), 64'(0));
        tick();
        cfg_write(3, 5, 1'b0, 1'b0);
        chk("collide tc", 64'(tc), 64'(4'h7));
        chk("collide cnt3", 64'(cnt(3)), 64'(0));
        chk("collide cnt0", 64'(cnt(0)), 64'(0));
        chk("badchan e5 tc", 64'(tc3), 64'(3'h7));
        cfg_write(3, 0, 1'b0, 1'b0);
        chk("clamp load tc3", 64'(tc[3]), 64'(0));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("clamp k%0d tc3", k), 64'(tc[3]), 64'(1));
            chk($sformatf("clamp k%0d cnt3", k), 64'(cnt(3)), 64'(0));
        end
        enable[3] = 1'b0;
        tick();
        chk("clamp disabled tc3", 64'(tc[3]), 64'(0));
        enable[3] = 1'b1;
        tick();
        chk("clamp reenabled tc3", 64'(tc[3]), 64'(1));

`ifdef COUNTER_BANK_CASCADE_EN
        begin
            int e, first, second;
            rst = 1'b1;
            do_reset();
            enable = 4'hF;
            tick();
            cfg_write(0, 4, 1'b0, 1'b0);
            cfg_write(1, 3, 1'b0, 1'b1);
            e = 3;
            first = -1;
            second = -1;
            while (e < 60 && second < 0) begin
                tick();
                e++;
                if (tc[1]) begin
                    if (first < 0) first = e;
                    else second = e;
                end
            end
            chk("cascade first tc1", 64'(first), 64'(15));
            chk("cascade period", 64'(second - first), 64'(12));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
